// File: rtl/vga_sink.sv
// VGA receive monitor: recovers pixel coordinates, checks sync timing, locks and signs each frame.
// Optional statistics counters (err_count, frame_count) are built only when VGA_SINK_STATS_EN is defined.
module vga_sink #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  vga_r,
  input  logic [1:0]  vga_g,
  input  logic [1:0]  vga_b,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_VIS_HI = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  V_VIS_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_VIS_HI = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  // input stage
  logic [5:0]  rgb_s1_q;
  logic        hs_s1_q, vs_s1_q, hs_prev_q, vs_prev_q;
  logic        hs_edge, vs_edge;

  // timing recovery
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic        boundary, line_bad, frame_bad, sat_err, timing_err;
  logic        visible;
  logic [9:0]  x_off, y_off;

  // lock and signature
  state_t      state_q, state_d;
  logic        acq_q, acq_d;
  logic        err_hit, done_hit;
  logic [15:0] sig_q, sig_d, frame_sig_q, frame_sig_d;
  logic        frame_done_q;

  // output stage
  logic        pix_valid_q;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic [5:0]  pix_rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_s1_q  <= '0;
      hs_s1_q   <= ~SYNC_POL;
      vs_s1_q   <= ~SYNC_POL;
      hs_prev_q <= ~SYNC_POL;
      vs_prev_q <= ~SYNC_POL;
    end else begin
      rgb_s1_q  <= {vga_b, vga_g, vga_r};
      hs_s1_q   <= vga_hsync;
      vs_s1_q   <= vga_vsync;
      hs_prev_q <= hs_s1_q;
      vs_prev_q <= vs_s1_q;
    end
  end

  assign hs_edge = (hs_s1_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
  assign vs_edge = (vs_s1_q == SYNC_POL) && (vs_prev_q != SYNC_POL);

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    vs_pend_d = vs_pend_q;
    boundary  = 1'b0;
    line_bad  = 1'b0;
    frame_bad = 1'b0;
    sat_err   = 1'b0;
    if (hs_edge) begin
      hcnt_d   = '0;
      line_bad = (hcnt_q != H_LAST);
      if (vs_pend_q || vs_edge) begin
        boundary  = 1'b1;
        frame_bad = (vcnt_q != V_LAST);
        vcnt_d    = '0;
        vs_pend_d = 1'b0;
      end else if (vcnt_q != CNT_MAX) begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end else begin
      if (hcnt_q == CNT_MAX) begin
        sat_err = 1'b1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      if (vs_edge) begin
        vs_pend_d = 1'b1;
      end
    end
  end

  assign timing_err = line_bad | frame_bad | sat_err;

  // The _d counts are the position of the pixel currently held in s1.
  assign visible = (hcnt_d >= H_VIS_LO) && (hcnt_d <= H_VIS_HI) &&
                   (vcnt_d >= V_VIS_LO) && (vcnt_d <= V_VIS_HI);
  assign x_off   = hcnt_d - H_VIS_LO;
  assign y_off   = vcnt_d - V_VIS_LO;

  always_comb begin
    state_d  = state_q;
    acq_d    = acq_q;
    err_hit  = 1'b0;
    done_hit = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (boundary) begin
          state_d = ACQUIRE;
          acq_d   = 1'b0;
        end
      end
      ACQUIRE: begin
        if (timing_err) begin
          state_d = UNLOCKED;
          err_hit = 1'b1;
        end else if (boundary) begin
          if (acq_q) begin
            state_d = LOCKED;
          end
          acq_d = 1'b1;
        end
      end
      LOCKED: begin
        // LOCKED is only entered at a boundary, so being here at a clean boundary means the whole frame was locked.
        if (timing_err) begin
          state_d = UNLOCKED;
          err_hit = 1'b1;
        end else if (boundary) begin
          done_hit = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    sig_d       = sig_q;
    frame_sig_d = frame_sig_q;
    if (boundary) begin
      sig_d = 16'hFFFF;
    end else if (visible) begin
      sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]} ^ {10'b0, rgb_s1_q};
    end
    if (done_hit) begin
      frame_sig_d = sig_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vs_pend_q    <= 1'b0;
      state_q      <= UNLOCKED;
      acq_q        <= 1'b0;
      sig_q        <= 16'hFFFF;
      frame_sig_q  <= '0;
      frame_done_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vs_pend_q    <= vs_pend_d;
      state_q      <= state_d;
      acq_q        <= acq_d;
      sig_q        <= sig_d;
      frame_sig_q  <= frame_sig_d;
      frame_done_q <= done_hit;
      pix_valid_q  <= visible && (state_q == LOCKED);
      if (visible && (state_q == LOCKED)) begin
        pix_x_q   <= x_off;
        pix_y_q   <= y_off[8:0];
        pix_rgb_q <= rgb_s1_q;
      end else begin
        pix_x_q   <= '0;
        pix_y_q   <= '0;
        pix_rgb_q <= '0;
      end
    end
  end

`ifdef VGA_SINK_STATS_EN
  logic [7:0]  err_count_q;
  logic [15:0] frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      if (err_hit && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (done_hit) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;
`else
  assign err_count   = '0;
  assign frame_count = '0;
`endif

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign locked     = (state_q == LOCKED);
  assign frame_done = frame_done_q;
  assign frame_sig  = frame_sig_q;

endmodule

// File: tb/tb_vga_sink.sv
// Bench for vga_sink on a reduced 16x11 raster; an active-low and an active-high instance share one stream.
module tb_vga_sink;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] r, g, b;
  logic hs, vs, hs_n, vs_n;

  logic p0_valid, p1_valid, lk0, lk1, fd0, fd1;
  logic [9:0] p0_x, p1_x;
  logic [8:0] p0_y, p1_y;
  logic [5:0] p0_rgb, p1_rgb;
  logic [15:0] sig0, sig1, fc0, fc1;
  logic [7:0] ec0, ec1;

  assign hs_n = ~hs;
  assign vs_n = ~vs;

  always #5 clk = ~clk;

  vga_sink #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
             .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst(rst), .vga_r(r), .vga_g(g), .vga_b(b), .vga_hsync(hs), .vga_vsync(vs),
    .pix_valid(p0_valid), .pix_x(p0_x), .pix_y(p0_y), .pix_rgb(p0_rgb), .locked(lk0),
    .frame_done(fd0), .frame_sig(sig0), .err_count(ec0), .frame_count(fc0));

  vga_sink #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
             .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)) dut_p (
    .clk(clk), .rst(rst), .vga_r(r), .vga_g(g), .vga_b(b), .vga_hsync(hs_n), .vga_vsync(vs_n),
    .pix_valid(p1_valid), .pix_x(p1_x), .pix_y(p1_y), .pix_rgb(p1_rgb), .locked(lk1),
    .frame_done(fd1), .frame_sig(sig1), .err_count(ec1), .frame_count(fc1));

  typedef struct {
    int mode;      // 0: (x^y)&63, 1: constant 6'h2A
    int fault;     // 0 none, 1 short line 5, 2 reset in line 5, 3 hsync lost
    bit lk;        // locked after the boundary starting this frame
    int done;      // frame_done pulses since previous row check
    int sig_mode;  // pattern of the frame whose signature is expected
    int valid;     // pix_valid cycles since previous row check
    int err;
    int fc;
  } row_t;

  localparam int NROWS = 18;
  row_t tbl[NROWS];

  int n_cmp = 0, n_bad = 0;
  int vcnt0 = 0, vcnt1 = 0, dcnt0 = 0, dcnt1 = 0;
  int last_v0 = 0, last_v1 = 0, last_d0 = 0, last_d1 = 0;

  bit cur_vis = 1'b0, h1_vis = 1'b0;
  logic [9:0] cur_x = '0, h1_x = '0;
  logic [8:0] cur_y = '0, h1_y = '0;
  logic [5:0] cur_rgb = '0, h1_rgb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int stat(input int v);
`ifdef VGA_SINK_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic logic [5:0] color(input int mode, input int x, input int y);
    if (mode == 1) return 6'h2A;
    return 6'((x ^ y) & 63);
  endfunction

  function automatic logic [15:0] misr(input int mode);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {10'b0, color(mode, x, y)};
    return s;
  endfunction

  // Pixel monitor: outputs carry the pixel that was on the pins two edges earlier.
  always begin
    @(posedge clk);
    #1;
    if (!h1_vis) begin
      check("valid_outside0", p0_valid, 0);
      check("valid_outside1", p1_valid, 0);
    end else begin
      if (p0_valid) check("pixel0", {p0_x, p0_y, p0_rgb}, {h1_x, h1_y, h1_rgb});
      if (p1_valid) check("pixel1", {p1_x, p1_y, p1_rgb}, {h1_x, h1_y, h1_rgb});
    end
    vcnt0 += int'(p0_valid);
    vcnt1 += int'(p1_valid);
    dcnt0 += int'(fd0);
    dcnt1 += int'(fd1);
    h1_vis = cur_vis;
    h1_x   = cur_x;
    h1_y   = cur_y;
    h1_rgb = cur_rgb;
  end

  task automatic drive_idle();
    hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
    cur_vis = 1'b0; cur_x = '0; cur_y = '0; cur_rgb = '0;
  endtask

  task automatic drive_pos(input int mode, input int l, input int p);
    int x, y;
    bit vis;
    logic [5:0] c;
    x = p - (HS + HB);
    y = l - (VS + VB);
    vis = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    c = vis ? color(mode, x, y) : 6'h00;
    hs = (p < HS) ? 1'b0 : 1'b1;
    vs = (l < VS) ? 1'b0 : 1'b1;
    r = c[1:0]; g = c[3:2]; b = c[5:4];
    cur_vis = vis; cur_x = 10'(x); cur_y = 9'(y); cur_rgb = c;
  endtask

  task automatic row_checks(input int row);
    row_t t;
    t = tbl[row];
    check($sformatf("row%0d_locked0", row), lk0, t.lk);
    check($sformatf("row%0d_locked1", row), lk1, t.lk);
    check($sformatf("row%0d_done0", row), dcnt0 - last_d0, t.done);
    check($sformatf("row%0d_done1", row), dcnt1 - last_d1, t.done);
    if (t.done > 0) begin
      check($sformatf("row%0d_sig0", row), sig0, misr(t.sig_mode));
      check($sformatf("row%0d_sig1", row), sig1, misr(t.sig_mode));
    end
    check($sformatf("row%0d_valid0", row), vcnt0 - last_v0, t.valid);
    check($sformatf("row%0d_valid1", row), vcnt1 - last_v1, t.valid);
    check($sformatf("row%0d_err0", row), ec0, stat(t.err));
    check($sformatf("row%0d_err1", row), ec1, stat(t.err));
    check($sformatf("row%0d_fcnt0", row), fc0, stat(t.fc));
    check($sformatf("row%0d_fcnt1", row), fc1, stat(t.fc));
    last_v0 = vcnt0; last_v1 = vcnt1; last_d0 = dcnt0; last_d1 = dcnt1;
  endtask

  task automatic silence();
    int d0, d1;
    d0 = dcnt0; d1 = dcnt1;
    for (int j = 0; j < 2500; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1000) begin
        check("nohs_still_locked0", lk0, 1);
        check("nohs_still_locked1", lk1, 1);
      end
      if (j == 1040) begin
        check("nohs_dropped0", lk0, 0);
        check("nohs_dropped1", lk1, 0);
      end
      drive_idle();
    end
    @(negedge clk);
    check("nohs_err_once0", ec0, stat(2));
    check("nohs_err_once1", ec1, stat(2));
    check("nohs_no_done0", dcnt0 - d0, 0);
    check("nohs_no_done1", dcnt1 - d1, 0);
  endtask

  task automatic run_frame(input int row);
    row_t t;
    int len;
    t = tbl[row];
    for (int l = 0; l < VT; l++) begin
      len = (t.fault == 1 && l == 5) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        @(negedge clk);
        if (l == 0 && p == 4) row_checks(row);
        if (t.fault == 1 && l == 6 && p == 1) begin
          check("short_line_hold0", lk0, 1);
          check("short_line_hold1", lk1, 1);
        end
        if (t.fault == 1 && l == 6 && p == 2) begin
          check("short_line_drop0", lk0, 0);
          check("short_line_drop1", lk1, 0);
        end
        if (t.fault == 2 && l == 5 && p == 4) begin
          check("midrst_pix0", {p0_valid, p0_x, p0_y, p0_rgb}, 0);
          check("midrst_ctl0", {lk0, fd0, sig0, ec0, fc0}, 0);
          check("midrst_pix1", {p1_valid, p1_x, p1_y, p1_rgb}, 0);
          check("midrst_ctl1", {lk1, fd1, sig1, ec1, fc1}, 0);
          rst = 1'b0;
        end
        if (t.fault == 3 && l == 0 && p == 5) begin
          silence();
          return;
        end
        drive_pos(t.mode, l, p);
        if (t.fault == 2 && l == 5 && p == 3) rst = 1'b1;
      end
    end
  endtask

  initial begin
    //          mode fault lk done sig valid err fc
    tbl[0]  = '{0, 0, 1'b0, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 0, 1'b0, 0, 0,  0, 0, 0};
    tbl[2]  = '{0, 0, 1'b1, 0, 0,  0, 0, 0};
    tbl[3]  = '{1, 0, 1'b1, 1, 0, 48, 0, 1};
    tbl[4]  = '{1, 0, 1'b1, 1, 1, 48, 0, 2};
    tbl[5]  = '{0, 1, 1'b1, 1, 1, 48, 0, 3};
    tbl[6]  = '{0, 0, 1'b0, 0, 0, 16, 1, 3};
    tbl[7]  = '{0, 0, 1'b0, 0, 0,  0, 1, 3};
    tbl[8]  = '{0, 0, 1'b1, 0, 0,  0, 1, 3};
    tbl[9]  = '{0, 3, 1'b1, 1, 0, 48, 1, 4};
    tbl[10] = '{0, 0, 1'b0, 0, 0,  0, 2, 4};
    tbl[11] = '{0, 0, 1'b0, 0, 0,  0, 2, 4};
    tbl[12] = '{1, 2, 1'b1, 0, 0,  0, 2, 4};
    tbl[13] = '{0, 0, 1'b0, 0, 0,  8, 0, 0};
    tbl[14] = '{0, 0, 1'b0, 0, 0,  0, 0, 0};
    tbl[15] = '{0, 0, 1'b1, 0, 0,  0, 0, 0};
    tbl[16] = '{1, 0, 1'b1, 1, 0, 48, 0, 1};
    tbl[17] = '{1, 0, 1'b1, 1, 1, 48, 0, 2};

    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("reset_pix0", {p0_valid, p0_x, p0_y, p0_rgb}, 0);
    check("reset_ctl0", {lk0, fd0, sig0, ec0, fc0}, 0);
    check("reset_pix1", {p1_valid, p1_x, p1_y, p1_rgb}, 0);
    check("reset_ctl1", {lk1, fd1, sig1, ec1, fc1}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NROWS; i++) run_frame(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
